// File: rtl/mont_digit_iter.sv
// Digit-serial Montgomery iteration: result = a*b*2^-NBITS mod m.
// Define MONT_ITER_FINAL_SUB_EN to add the final conditional subtract.
module mont_digit_iter #(
  parameter int NBITS  = 4096,
  parameter int PBITS  = 1,
  parameter int MLSIZE = 1 << PBITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [NBITS-1:0]                  a,
  input  logic [NBITS-1:0]                  b,
  input  logic [NBITS-1:0]                  m,
  input  logic [PBITS-1:0]                  m_inv_neg,
  input  logic                              tbl_done,
  input  logic [(MLSIZE-1)*NBITS-1:0]       bxn_tbl,
  input  logic [MLSIZE*(NBITS+PBITS)-1:0]   mxn_tbl,
  output logic                              busy,
  output logic                              done,
  output logic [NBITS:0]                    result
);

  localparam int NDIG = NBITS / PBITS;
  localparam int IW   = $clog2(NDIG + 1);
  localparam int MW   = NBITS + PBITS;
  localparam int SW   = NBITS + 2;
  localparam int SUMW = NBITS + PBITS + 2;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ITER,
    S_FINAL,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [NBITS-1:0]  a_q, a_d;
  logic [NBITS:0]    t_q, t_d;
  logic [IW-1:0]     i_q, i_d;
  logic [PBITS-1:0]  minv_q, minv_d;
  logic [NBITS:0]    res_q, res_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [PBITS-1:0]  dig;
  logic [PBITS-1:0]  qd;
  logic [NBITS-1:0]  bx;
  logic [MW-1:0]     mx;
  logic [SW-1:0]     s;
  logic [SUMW-1:0]   sum;
  logic [NBITS:0]    t_nxt;
  logic              unused_ok;

`ifdef MONT_ITER_FINAL_SUB_EN
  logic [NBITS-1:0]  m_q, m_d;
  logic [NBITS:0]    t_red;
`endif

  assign dig = a_q[PBITS-1:0];

  // Select k*b mod m for the current digit; entry 0 is zero.
  always_comb begin
    bx = '0;
    for (int k = 1; k < MLSIZE; k++) begin
      if (int'(dig) == k) begin
        bx = bxn_tbl[(k-1)*NBITS +: NBITS];
      end
    end
  end

  assign s  = {1'b0, t_q} + {2'b00, bx};
  assign qd = s[PBITS-1:0] * minv_q;

  // Select q*m so the low digit of S + q*m cancels to zero.
  always_comb begin
    mx = '0;
    for (int k = 1; k < MLSIZE; k++) begin
      if (int'(qd) == k) begin
        mx = mxn_tbl[(k-1)*MW +: MW];
      end
    end
  end

  assign sum   = {{PBITS{1'b0}}, s} + {2'b00, mx};
  assign t_nxt = sum[PBITS +: NBITS+1];

`ifdef MONT_ITER_FINAL_SUB_EN
  assign t_red = (t_q >= {1'b0, m_q}) ? t_q - {1'b0, m_q} : t_q;
  assign unused_ok = ^{b, mxn_tbl[MLSIZE*MW-1 -: MW],
                       sum[SUMW-1], sum[PBITS-1:0]};
`else
  assign unused_ok = ^{b, m, mxn_tbl[MLSIZE*MW-1 -: MW],
                       sum[SUMW-1], sum[PBITS-1:0]};
`endif

  // Next-state and datapath update for the iteration FSM.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    t_d     = t_q;
    i_d     = i_q;
    minv_d  = minv_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MONT_ITER_FINAL_SUB_EN
    m_d     = m_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          minv_d  = m_inv_neg;
`ifdef MONT_ITER_FINAL_SUB_EN
          m_d     = m;
`endif
          t_d     = '0;
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tbl_done) begin
          i_d     = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        t_d = t_nxt;
        a_d = a_q >> PBITS;
        i_d = i_q + IW'(1);
        if (i_q == LAST) begin
`ifdef MONT_ITER_FINAL_SUB_EN
          state_d = S_FINAL;
`else
          res_d   = t_nxt;
          done_d  = 1'b1;
          state_d = S_DONE;
`endif
        end
      end
      S_FINAL: begin
`ifdef MONT_ITER_FINAL_SUB_EN
        res_d   = t_red;
        done_d  = 1'b1;
        state_d = S_DONE;
`else
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with async clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      t_q     <= '0;
      i_q     <= '0;
      minv_q  <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MONT_ITER_FINAL_SUB_EN
      m_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      t_q     <= t_d;
      i_q     <= i_d;
      minv_q  <= minv_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MONT_ITER_FINAL_SUB_EN
      m_q     <= m_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;

endmodule

// File: tb/tb_mont_digit_iter.sv
// Bench for mont_digit_iter: directed 8-bit radix-4 vectors
// plus a 24-bit radix-8 instance checked by congruence.
module tb_mont_digit_iter;

  localparam int NB = 8;
  localparam int PB = 2;
  localparam int ML = 4;
  localparam int WN = 24;
  localparam int WP = 3;
  localparam int WL = 8;

`ifdef MONT_ITER_FINAL_SUB_EN
  localparam int NLAT = NB / PB + 2;
  localparam int WLAT = WN / WP + 2;
  localparam bit SUB  = 1'b1;
`else
  localparam int NLAT = NB / PB + 1;
  localparam int WLAT = WN / WP + 1;
  localparam bit SUB  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  n_start, n_tdone, n_busy, n_done;
  logic [NB-1:0]         n_a, n_b, n_m;
  logic [PB-1:0]         n_minv;
  logic [(ML-1)*NB-1:0]  n_bxn;
  logic [ML*(NB+PB)-1:0] n_mxn;
  logic [NB:0]           n_res;

  logic                  w_start, w_tdone, w_busy, w_done;
  logic [WN-1:0]         w_a, w_b, w_m;
  logic [WP-1:0]         w_minv;
  logic [(WL-1)*WN-1:0]  w_bxn;
  logic [WL*(WN+WP)-1:0] w_mxn;
  logic [WN:0]           w_res;

  mont_digit_iter #(.NBITS(NB), .PBITS(PB)) u_n (
    .clk(clk), .rst_n(rst_n), .start(n_start),
    .a(n_a), .b(n_b), .m(n_m), .m_inv_neg(n_minv),
    .tbl_done(n_tdone), .bxn_tbl(n_bxn), .mxn_tbl(n_mxn),
    .busy(n_busy), .done(n_done), .result(n_res)
  );

  mont_digit_iter #(.NBITS(WN), .PBITS(WP)) u_w (
    .clk(clk), .rst_n(rst_n), .start(w_start),
    .a(w_a), .b(w_b), .m(w_m), .m_inv_neg(w_minv),
    .tbl_done(w_tdone), .bxn_tbl(w_bxn), .mxn_tbl(w_mxn),
    .busy(w_busy), .done(w_done), .result(w_res)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic n_tbl(input int bv);
    for (int k = 1; k < ML; k++)
      n_bxn[(k-1)*NB +: NB] = NB'((k * bv) % 13);
    for (int k = 1; k <= ML; k++)
      n_mxn[(k-1)*(NB+PB) +: NB+PB] = (NB+PB)'(k * 13);
  endtask

  // Counts cycles from the first ITER cycle up to done.
  task automatic n_wait(input int n0, output int n);
    n = n0;
    while (!n_done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic n_op(input int av, input int bv,
                      input int er, input string tag);
    int n;
    n_tbl(bv);
    n_a = NB'(av);
    n_b = NB'(bv);
    n_start = 1'b1;
    tick();
    n_start = 1'b0;
    chk({tag, ".busy1"}, n_busy, 1);
    tick();
    tick();
    n_tdone = 1'b1;
    tick();
    n_tdone = 1'b0;
    n_wait(1, n);
    chk({tag, ".lat"}, n, NLAT);
    chk({tag, ".res"}, n_res, er);
    chk({tag, ".busyd"}, n_busy, 1);
    tick();
    chk({tag, ".busy0"}, n_busy, 0);
    chk({tag, ".done0"}, n_done, 0);
  endtask

  task automatic w_op(input longint unsigned mv,
                      input longint unsigned av,
                      input longint unsigned bv,
                      input bit early, input string tag);
    int n;
    longint unsigned r, lim;
    for (int k = 0; k < WL; k++)
      if (((mv * longint'(k)) + 1) % WL == 0) w_minv = WP'(k);
    for (int k = 1; k < WL; k++)
      w_bxn[(k-1)*WN +: WN] = WN'((longint'(k) * bv) % mv);
    for (int k = 1; k <= WL; k++)
      w_mxn[(k-1)*(WN+WP) +: WN+WP] = (WN+WP)'(longint'(k) * mv);
    w_m = WN'(mv);
    w_a = WN'(av);
    w_b = WN'(bv);
    w_start = 1'b1;
    tick();
    w_start = 1'b0;
    if (!early) tick();
    w_tdone = 1'b1;
    tick();
    w_tdone = 1'b0;
    n = 1;
    while (!w_done && n < 60) begin
      tick();
      n++;
    end
    chk({tag, ".lat"}, n, WLAT);
    r = longint'(w_res);
    lim = SUB ? mv : 2 * mv;
    chk({tag, ".cong"}, ((r % mv) << WN) % mv, (av * bv) % mv);
    chk({tag, ".range"}, r < lim, 1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit ok;
    longint unsigned mv, av, bv;
    rst_n = 1'b0;
    n_start = 0; n_tdone = 0; n_a = 0; n_b = 0;
    n_m = 8'd13; n_minv = 2'd3; n_bxn = '0; n_mxn = '0;
    w_start = 0; w_tdone = 0; w_a = 0; w_b = 0;
    w_m = 0; w_minv = 0; w_bxn = '0; w_mxn = '0;
    tick();
    tick();
    chk("rst.busy", n_busy, 0);
    chk("rst.done", n_done, 0);
    chk("rst.res", n_res, 0);
    rst_n = 1'b1;
    tick();

    n_op(5, 7, 1, "a5b7");
    n_op(1, 1, 3, "a1b1");
    n_op(0, 9, 0, "a0b9");
    n_op(12, 12, 3, "a12b12");

    // Long wait for tables, then a start during ITER.
    n_tbl(7);
    n_a = 8'd5;
    n_start = 1'b1;
    tick();
    n_start = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!n_busy || n_done) ok = 1'b0;
      tick();
    end
    chk("hold.nodone", ok, 1);
    n_tdone = 1'b1;
    tick();
    n_tdone = 1'b0;
    n_a = 8'd1;
    n_start = 1'b1;
    tick();
    n_start = 1'b0;
    n_wait(2, n);
    chk("hold.lat", n, NLAT);
    chk("hold.res", n_res, 1);
    n_start = 1'b1;
    tick();
    n_start = 1'b0;
    chk("ovl.busy0", n_busy, 0);
    tick();
    chk("ovl.idle", n_busy, 0);

    // Reset during ITER, then a stray tbl_done in IDLE.
    n_tbl(12);
    n_a = 8'd12;
    n_start = 1'b1;
    tick();
    n_start = 1'b0;
    tick();
    tick();
    n_tdone = 1'b1;
    tick();
    n_tdone = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst.busy", n_busy, 0);
    chk("mrst.done", n_done, 0);
    chk("mrst.res", n_res, 0);
    tick();
    rst_n = 1'b1;
    tick();
    n_tdone = 1'b1;
    tick();
    n_tdone = 1'b0;
    chk("stray.busy", n_busy, 0);
    tick();
    chk("stray.done", n_done, 0);
    n_op(5, 7, 1, "post");

    // Wide instance: boundary operands and pseudo-random sweep.
    w_op(64'd13, 64'd12, 64'd12, 1'b1, "w.small");
    w_op(64'hFFFFFD, 64'hFFFFFC, 64'hFFFFFC, 1'b0, "w.max");
    for (int v = 0; v < 20; v++) begin
      mv = longint'(($urandom & 32'hFFFFFF) | 32'h800001);
      av = longint'($urandom) % mv;
      bv = longint'($urandom) % mv;
      w_op(mv, av, bv, v[0], $sformatf("w.r%0d", v));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
